// File: rtl/adder_operand_packer_seq_pkg.sv
// Shared types and constants for the adder operand packer.
package adder_operand_packer_seq_pkg;

    // Packing FSM: IDLE holds nothing, HALF holds the low-lane operand.
    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } pack_state_e;

    // Per-lane valid encodings for the two-lane adder input.
    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

endpackage

// File: rtl/adder_operand_packer_seq_if.sv
// Operand-in / packet-out handshake bundle for the adder operand packer.
interface adder_operand_packer_seq_if #(
    parameter int DATA_WIDTH = 4
);
    // Upstream operand stream
    logic                    i_valid;
    logic [DATA_WIDTH-1:0]   i_data;
    logic                    i_last;
    logic                    o_ready;
    // Downstream two-lane packet
    logic [1:0]              o_valid;
    logic [2*DATA_WIDTH-1:0] o_data_bus;
    logic                    i_ready;

    // Packer side
    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data_bus
    );

    // Source / sink side
    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data_bus
    );
endinterface

// File: rtl/pkt_counter_seq.sv
// Enable-gated wrapping event counter with asynchronous active-low reset.
module pkt_counter_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count one per enabled edge; natural wrap at 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  count <= '0;
        else if (en) count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/adder_operand_packer_seq.sv
// Packs a serial operand stream into two-lane packets for the sequential
// adder. First operand of a pair lands in the low lane; an odd operand
// tagged last is flushed alone in the low lane with the high lane zeroed.
module adder_operand_packer_seq
    import adder_operand_packer_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_en,
    adder_operand_packer_seq_if.slave      bus,
    output logic                           o_half,
    output logic [CNT_WIDTH-1:0]           o_pkt_cnt
);

    pack_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0]   buf_q;
    logic                    buf_ld;
    logic [1:0]              valid_q;
    logic [2*DATA_WIDTH-1:0] data_q;
    logic                    pkt_ld;
    logic [1:0]              pkt_valid;
    logic [2*DATA_WIDTH-1:0] pkt_data;
    logic                    out_full;
    logic                    consume;
    logic                    xfer;

    // The output slot may be refilled on the same edge it drains, so ready
    // looks through to downstream ready when the slot is occupied.
    assign out_full    = (valid_q != LANE_NONE);
    assign consume     = out_full & i_en & bus.i_ready;
    assign bus.o_ready = i_en & (~out_full | bus.i_ready);
    assign xfer        = bus.i_valid & bus.o_ready;

    assign bus.o_valid    = valid_q;
    assign bus.o_data_bus = data_q;
    assign o_half         = (state_q == HALF);

    // Next-state and packet assembly; i_last is irrelevant once a pair completes.
    always_comb begin
        state_d   = state_q;
        buf_ld    = 1'b0;
        pkt_ld    = 1'b0;
        pkt_valid = LANE_NONE;
        pkt_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (bus.i_last) begin
                        pkt_ld    = 1'b1;
                        pkt_valid = LANE_LO;
                        pkt_data  = {{DATA_WIDTH{1'b0}}, bus.i_data};
                    end else begin
                        buf_ld  = 1'b1;
                        state_d = HALF;
                    end
                end
            end
            HALF: begin
                if (xfer) begin
                    pkt_ld    = 1'b1;
                    pkt_valid = LANE_BOTH;
                    pkt_data  = {bus.i_data, buf_q};
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and held low-lane operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (buf_ld) buf_q <= bus.i_data;
        end
    end

    // Output packet register: a fresh load wins over a drain on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= LANE_NONE;
            data_q  <= '0;
        end else if (pkt_ld) begin
            valid_q <= pkt_valid;
            data_q  <= pkt_data;
        end else if (consume) begin
            valid_q <= LANE_NONE;
        end
    end

    pkt_counter_seq #(
        .WIDTH (CNT_WIDTH)
    ) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (consume),
        .count (o_pkt_cnt)
    );

endmodule

// File: tb/tb_adder_operand_packer_seq.sv
// Directed scoreboard bench for adder_operand_packer_seq (4-bit lanes, 4-bit counter).
module tb_adder_operand_packer_seq;

    localparam int DW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]      v;
        logic [2*DW-1:0] d;
    } pkt_t;

    logic          clk;
    logic          rst_n;
    logic          i_en;
    logic          o_half;
    logic [CW-1:0] o_pkt_cnt;

    adder_operand_packer_seq_if #(.DATA_WIDTH(DW)) bus ();

    adder_operand_packer_seq #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .bus       (bus),
        .o_half    (o_half),
        .o_pkt_cnt (o_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    pkt_t     sb_q[$];
    bit       m_half;
    logic [DW-1:0] m_buf;
    logic [CW-1:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one operand (called just after a negedge) and hold it until accepted.
    // Returns at the negedge following the accepting edge, with i_valid dropped.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = l;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.o_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL accept_timeout observed=0 expected=1 data=%0h", d);
        end
        if (ok) begin
            if (!m_half) begin
                if (l) sb_q.push_back('{v: 2'b01, d: {{DW{1'b0}}, d}});
                else begin m_half = 1'b1; m_buf = d; end
            end else begin
                sb_q.push_back('{v: 2'b11, d: {d, m_buf}});
                m_half = 1'b0;
            end
        end
    endtask

    // Compare the visible output packet against the oldest expected packet.
    task automatic pop_chk(input string tag);
        pkt_t e;
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb_empty observed=%0h expected=none", tag, bus.o_data_bus);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(bus.o_valid), 32'(e.v));
            chk({tag, "_data"},  32'(bus.o_data_bus), 32'(e.d));
        end
    endtask

    initial begin
        m_half = 1'b0; m_buf = '0; exp_cnt = '0;
        rst_n = 1'b0; i_en = 1'b1;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_data",  32'(bus.o_data_bus), 0);
        chk("rst_half",  32'(o_half), 0);
        chk("rst_cnt",   32'(o_pkt_cnt), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pair pack: 0x5 then 0xE
        send(4'h5, 1'b0);
        chk("pair_half", 32'(o_half), 1);
        chk("pair_nopkt", 32'(bus.o_valid), 0);
        send(4'hE, 1'b0);
        chk("pair_half_clr", 32'(o_half), 0);
        chk("pair_sum", 32'(5'(bus.o_data_bus[7:4]) + 5'(bus.o_data_bus[3:0])), 32'h13);
        pop_chk("pair");
        @(negedge clk);
        exp_cnt++;
        chk("pair_drained", 32'(bus.o_valid), 0);
        chk("pair_cnt", 32'(o_pkt_cnt), 32'(exp_cnt));

        // Odd flush from IDLE
        send(4'h7, 1'b1);
        chk("flush_half", 32'(o_half), 0);
        pop_chk("flush");
        @(negedge clk);
        exp_cnt++;
        chk("flush_cnt", 32'(o_pkt_cnt), 32'(exp_cnt));

        // Backpressure
        bus.i_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        pop_chk("bp_pair");
        bus.i_valid = 1'b1; bus.i_data = 4'h3; bus.i_last = 1'b0;
        #1 chk("bp_ready_low", 32'(bus.o_ready), 0);
        repeat (2) @(negedge clk);
        chk("bp_hold_data",  32'(bus.o_data_bus), 32'h21);
        chk("bp_hold_valid", 32'(bus.o_valid), 32'h3);
        chk("bp_not_taken",  32'(o_half), 0);
        bus.i_ready = 1'b1;
        #1 chk("bp_ready_high", 32'(bus.o_ready), 1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        exp_cnt++;
        m_half = 1'b1; m_buf = 4'h3;
        chk("bp_drained", 32'(bus.o_valid), 0);
        chk("bp_took3",   32'(o_half), 1);
        chk("bp_cnt",     32'(o_pkt_cnt), 32'(exp_cnt));

        // Asynchronous reset while holding 0x3
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 0);
        chk("arst_half",  32'(o_half), 0);
        chk("arst_data",  32'(bus.o_data_bus), 0);
        chk("arst_cnt",   32'(o_pkt_cnt), 0);
        m_half = 1'b0; sb_q.delete(); exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b0;
        @(negedge clk);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        pop_chk("arst_pair");

        // Enable gating with a held packet
        i_en = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1; bus.i_data = 4'h9; bus.i_last = 1'b1;
        #1 chk("en_ready", 32'(bus.o_ready), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("en_valid", 32'(bus.o_valid), 32'h3);
            chk("en_data",  32'(bus.o_data_bus), 32'h21);
            chk("en_cnt",   32'(o_pkt_cnt), 32'(exp_cnt));
        end
        bus.i_valid = 1'b0; bus.i_last = 1'b0;
        i_en = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("en_drain_valid", 32'(bus.o_valid), 0);
        chk("en_drain_cnt",   32'(o_pkt_cnt), 32'(exp_cnt));

        // Counter wrap: 16 flushed packets, counter passes 15 -> 0
        for (int p = 0; p < 16; p++) begin
            send(4'(p), 1'b1);
            pop_chk("wrap_pkt");
            @(negedge clk);
            exp_cnt++;
            chk("wrap_cnt", 32'(o_pkt_cnt), 32'(exp_cnt));
        end

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_operand_packer_seq.md
Name: adder_operand_packer_seq

Overview:
- Transmit-side feeder for the sequential variable adder.
- Accepts a serial stream of single operands on a valid/ready handshake.
- Packs consecutive operands into the adder's two-lane input format: a 2*DATA_WIDTH bus plus a 2-bit per-lane valid.
- An odd trailing operand (marked i_last) is flushed as a half-valid packet. Sits between an operand source (buffer/NoC port) and the adder.

Parameters:
- DATA_WIDTH, 4, width of one operand and of each output lane.
- CNT_WIDTH, 16, width of the emitted-packet counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- i_en  input  1  block enable
- i_valid  input  1  upstream operand valid
- i_data  input  DATA_WIDTH  upstream operand
- i_last  input  1  final operand of a reduction group; forces flush
- o_ready  output  1  upstream may transfer this cycle
- o_valid  output  2  per-lane valid; bit0 = low lane (data_b), bit1 = high lane (data_a)
- o_data_bus  output  2*DATA_WIDTH  high lane at [DATA_WIDTH+:DATA_WIDTH], low lane at [DATA_WIDTH-1:0]
- i_ready  input  1  downstream consumes the output packet at this clock edge
- o_half  output  1  one operand is held, waiting for its partner
- o_pkt_cnt  output  CNT_WIDTH  number of packets emitted (consumed downstream)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, o_valid=2'b00, o_data_bus=0, hold buffer=0, o_pkt_cnt=0, o_half=0.
  - Reset mid-operation discards the held operand and any undelivered packet.
- Output register:
  - out_full = (o_valid != 2'b00).
  - A packet stays stable until a clock edge where i_en=1 and i_ready=1; o_valid then clears, unless a new packet loads on the same edge.
- o_ready = i_en & (~out_full | i_ready). This is combinational from registers and i_ready.
- Transfer = i_valid & o_ready, sampled at the rising edge.
- FSM states:
  - IDLE: no operand held.
    - On transfer with i_last=0: buffer<=i_data; go to HALF.
    - On transfer with i_last=1: output<={DATA_WIDTH zeros, i_data}, o_valid<=2'b01; stay in IDLE.
  - HALF: buffer holds the low operand; o_half=1.
    - On transfer: output<={i_data, buffer}, o_valid<=2'b11; go to IDLE. i_last is ignored here because the pair is already complete.
- Latency: the packet is visible in the cycle after the edge that accepted the completing (or flushing) operand.
- Unused lane is driven to zero, never x.
- Simultaneous consume and load: when out_full, i_ready=1 and a packet-completing transfer occur on the same edge, the new packet replaces the old one. The counter increments once for the consumed packet.
- i_en=0: o_ready=0; state, buffer and output register are frozen; i_ready is ignored and nothing drains.
- o_pkt_cnt increments on every edge where out_full & i_en & i_ready. It wraps from 2^CNT_WIDTH-1 to 0.
- Lane order matches the adder: the first operand goes in the low lane, the second in the high lane. The adder sum is lane-order independent.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=1'b0, HALF=1'b1).
  - Lane valid constants: LANE_LO=2'b01, LANE_HI=2'b10, LANE_BOTH=2'b11.
- Natural sub-module: pkt_counter_seq, a parameterised enable-gated wrapping counter with asynchronous active-low reset, reused for NoC statistics.
- The packing FSM and output register stay in the top module.

Test Plan:
- Pair pack (DATA_WIDTH=4, i_en=1, i_ready=1): send 0x5, then 0xE with i_last=0.
  - Required: o_data_bus=8'hE5 and o_valid=2'b11 for one cycle; o_pkt_cnt=1.
  - Chained adder outputs 5'h13.
- Odd flush: send 0x7 with i_last=1 from IDLE.
  - Required: o_data_bus=8'h07, o_valid=2'b01; o_half stays 0.
- Backpressure: i_ready=0; send 0x1, 0x2, then offer 0x3.
  - Required: after the pair loads, o_ready=0 and 0x3 is not accepted; 8'h21/2'b11 is held stable.
  - After i_ready=1 for one edge: packet drains, o_ready=1, and 0x3 is accepted into HALF.
- Enable gating: i_en=0 with i_valid=1, i_ready=1 and a packet 8'h21 held.
  - Required: o_ready=0; o_valid, o_data_bus and o_pkt_cnt unchanged for 3 cycles.
- Reset mid-HALF: accept 0x3, then pulse rst_n=0 asynchronously (mid-cycle).
  - Required: o_valid=2'b00, o_half=0 and o_data_bus=0 immediately.
  - After release, send 0x1, 0x2: required 8'h21 with 2'b11, no trace of 0x3.
- Counter wrap (CNT_WIDTH=4): emit 16 packets with i_ready=1.
  - Required: o_pkt_cnt reads 15, then 0.
